// File: rtl/vpl_cla_result_fifo.sv
// Result-capture FIFO for the 4-bit carry-look-ahead add/subtract unit.
// Computes C/V/Z/N flags for each pushed sum, queues {s, C, V, Z, N} and
// presents the oldest entry show-ahead through a valid/ready handshake.
// Keeps a sticky signed-overflow flag for software polling.
module vpl_cla_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    x,
    input  logic [3:0]    y,
    input  logic          As_Sel,
    input  logic [3:0]    s,
    input  logic          Cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_s,
    output logic          out_c,
    output logic          out_v,
    output logic          out_z,
    output logic          out_n,
    output logic [CW-1:0] count,
    output logic          ovf_sticky,
    input  logic          ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    yb;
    logic          flag_c;
    logic          flag_v;
    logic          flag_z;
    logic          flag_n;
    logic [7:0]    entry_in;
    logic [7:0]    head;

    // Occupancy comes from the counter, so pointers can wrap freely.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Condition flags of the presented sum; y is re-inverted for subtract so
    // the overflow test sees the operand the adder actually used.
    always_comb begin
        yb       = y ^ {4{As_Sel}};
        flag_c   = Cout;
        flag_v   = (x[3] == yb[3]) && (s[3] != x[3]);
        flag_z   = (s == 4'b0000);
        flag_n   = s[3];
        entry_in = {s, flag_c, flag_v, flag_z, flag_n};
    end

    // Entry storage, written at the tail on every accepted push.
    // NOTE: storage has no reset; the count gates every read, so stale data
    // is never visible and the array can map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a pushed overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (push && flag_v) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign head = mem[rd_ptr];

    // Show-ahead head outputs, forced to zero while the FIFO is empty.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        out_s = 4'b0000;
        out_c = 1'b0;
        out_v = 1'b0;
        out_z = 1'b0;
        out_n = 1'b0;
        if (!empty) begin
            out_s = head[7:4];
            out_c = head[3];
            out_v = head[2];
            out_z = head[1];
            out_n = head[0];
        end
    end

endmodule

// File: tb/tb_vpl_cla_result_fifo.sv
// Scoreboard bench for vpl_cla_result_fifo: stimulus queues hand-computed
// entries {s, C, V, Z, N}; a monitor pops and compares on every handshake.
module tb_vpl_cla_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic       As_Sel;
    logic [3:0] s;
    logic       Cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s;
    logic       out_c;
    logic       out_v;
    logic       out_z;
    logic       out_n;
    logic [2:0] count;
    logic       ovf_sticky;
    logic       ovf_clr;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb_q[$];

    vpl_cla_result_fifo #(.DEPTH(4), .CW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .As_Sel     (As_Sel),
        .s          (s),
        .Cout       (Cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_z      (out_z),
        .out_n      (out_n),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: each accepted head must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_head", {out_s, out_c, out_v, out_z, out_n}, 8'hxx);
            end else begin
                check("head", {out_s, out_c, out_v, out_z, out_n}, sb_q.pop_front());
            end
        end
    end

    // One-cycle push; the entry is queued only when the FIFO should accept it.
    task automatic push(input logic [3:0] xx, input logic [3:0] yy, input logic as_sel,
                        input logic [3:0] ss, input logic co, input bit accept,
                        input logic [7:0] exp);
        x        = xx;
        y        = yy;
        As_Sel   = as_sel;
        s        = ss;
        Cout     = co;
        in_valid = 1'b1;
        if (accept) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    logic [3:0] stream_s   [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    logic [7:0] stream_exp [8] = '{8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1, 8'hF1, 8'h02, 8'h10};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        x = '0; y = '0; As_Sel = 1'b0; s = '0; Cout = 1'b0;
        #2;
        check("rst_count", 8'(count), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_ovf", 8'(ovf_sticky), 8'd0);
        check("rst_head_zero", {out_s, out_c, out_v, out_z, out_n}, 8'h00);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5 + 3 overflows into a negative result.
        push(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 8'b1000_0101);
        check("add_count", 8'(count), 8'd1);
        check("add_out_valid", 8'(out_valid), 8'd1);
        check("add_ovf", 8'(ovf_sticky), 8'd1);
        drain(1);

        // 3 - 3: zero, no borrow, sticky flag untouched.
        push(4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1, 1'b1, 8'b0000_1010);
        check("sub_zero_ovf_kept", 8'(ovf_sticky), 8'd1);
        drain(1);
        check("empty_after_drain", 8'(out_valid), 8'd0);

        // Clear the sticky flag, then push 7 - (-8) with clear held: set wins.
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        check("ovf_cleared", 8'(ovf_sticky), 8'd0);
        push(4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1, 8'b1111_0101);
        ovf_clr = 1'b0;
        check("ovf_set_wins", 8'(ovf_sticky), 8'd1);
        drain(1);

        // Fill to full, then a dropped fifth push.
        for (int i = 1; i <= 4; i++) begin
            push(4'(i), 4'b0000, 1'b0, 4'(i), 1'b0, 1'b1, {4'(i), 4'b0000});
        end
        check("full_count", 8'(count), 8'd4);
        check("full_in_ready", 8'(in_ready), 8'd0);
        push(4'd9, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 8'h00);
        check("drop_count", 8'(count), 8'd4);
        drain(4);
        check("drained_out_valid", 8'(out_valid), 8'd0);
        check("drained_count", 8'(count), 8'd0);
        check("drained_head_zero", {out_s, out_c, out_v, out_z, out_n}, 8'h00);

        // Prefill two, then stream with simultaneous push and pop.
        for (int i = 0; i < 2; i++) begin
            push(stream_s[i], 4'd0, 1'b0, stream_s[i], 1'b0, 1'b1, stream_exp[i]);
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            push(stream_s[i], 4'd0, 1'b0, stream_s[i], 1'b0, 1'b1, stream_exp[i]);
            check("stream_count", 8'(count), 8'd2);
        end
        drain(2);
        check("stream_end_count", 8'(count), 8'd0);

        // Reset mid-operation discards queued entries.
        for (int i = 0; i < 3; i++) begin
            push(4'd5, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1, 8'h50);
        end
        check("pre_reset_count", 8'(count), 8'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_count", 8'(count), 8'd0);
        check("mid_rst_out_valid", 8'(out_valid), 8'd0);
        check("mid_rst_in_ready", 8'(in_ready), 8'd1);
        check("mid_rst_ovf", 8'(ovf_sticky), 8'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(4'd6, 4'd0, 1'b0, 4'd6, 1'b0, 1'b1, 8'h60);
        check("post_rst_count", 8'(count), 8'd1);
        drain(1);
        check("post_rst_empty", 8'(out_valid), 8'd0);
        check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vpl_cla_result_fifo.md
Name: vpl_cla_result_fifo

Overview:
Downstream result-capture stage for the 4-bit carry-look-ahead add/subtract unit. Each cycle the upstream sequencer presents an operand pair, the add/sub select and the adder's combinational sum/carry. This block computes the condition flags (C, V, Z, N) and pushes sum+flags into a small FIFO. Consumers drain the FIFO through a valid/ready handshake. A sticky overflow flag is kept for software polling.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CW, 3, count width; must equal clog2(DEPTH+1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a result this cycle
in_ready  output  1  space available (= !full)
x  input  4  operand A presented to the adder
y  input  4  operand B presented to the adder (before As_Sel inversion)
As_Sel  input  1  0 = add, 1 = subtract (x - y)
s  input  4  adder sum output
Cout  input  1  adder carry-out
out_valid  output  1  FIFO head valid (= !empty)
out_ready  input  1  consumer accepts head
out_s  output  4  head sum
out_c  output  1  head carry (raw Cout; for subtract 1 = no borrow)
out_v  output  1  head signed overflow
out_z  output  1  head zero flag
out_n  output  1  head negative flag (s[3])
count  output  CW  entries currently held
ovf_sticky  output  1  set by any pushed entry with V=1
ovf_clr  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst_n low, asynchronous): write/read pointers = 0, count = 0, ovf_sticky = 0. Outputs at reset: in_ready = 1, out_valid = 0. out_s/out_c/out_v/out_z/out_n = 0 while empty: the head outputs are gated to zero when count = 0. Storage contents need no reset.
- Flag computation (combinational, at push): yb = y ^ {4{As_Sel}}.
  - V = (x[3] == yb[3]) & (s[3] != x[3]).
  - Z = (s == 4'b0).
  - N = s[3].
  - C = Cout.
- Entry format: {s[3:0], C, V, Z, N}, 8 bits.
- Push = in_valid & in_ready. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH on the rising edge.
- Pop = out_valid & out_ready. rd_ptr increments modulo DEPTH.
- Head outputs are show-ahead: combinational read of storage at rd_ptr.
- Latency: a pushed entry appears on the out_* ports in the cycle after the push. There is no same-cycle bypass, even when the FIFO is empty.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full (count = DEPTH):
  - in_ready = 0; in_valid is ignored and the entry is dropped.
  - A pop in the full cycle frees space; in_ready rises next cycle.
- Empty (count = 0): out_valid = 0; out_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer comparison.
- ovf_sticky:
  - Set on a push whose V = 1.
  - Cleared when ovf_clr = 1.
  - Set and clear in the same cycle: set wins, and the flag stays 1.
- Inputs x/y/As_Sel/s/Cout are sampled only on push. Their values in other cycles have no effect.
- Reset asserted mid-operation: FIFO empties immediately and all queued entries are lost. First push is accepted in the first clock edge after rst_n deasserts.

Test Plan:
- Add 5+3 (x=0101, y=0011, As_Sel=0, s=1000, Cout=0), push into an empty FIFO:
  - Next cycle: out_valid=1, out_s=1000, C=0, V=1, Z=0, N=1; count=1; ovf_sticky=1.
- Subtract 3-3 (x=0011, y=0011, As_Sel=1, s=0000, Cout=1):
  - Head: out_s=0000, C=1, V=0, Z=1, N=0; ovf_sticky unchanged.
- Subtract 7-(-8) (x=0111, y=1000, As_Sel=1, s=1111, Cout=0):
  - Head: C=0, V=1, N=1, Z=0.
  - Hold ovf_clr=1 in the same cycle as this push: ovf_sticky=1 afterwards.
- Hold out_ready=0 and push 4 distinct sums 1, 2, 3, 4:
  - count=4, in_ready=0.
  - A 5th push with s=9 is dropped.
  - Then out_ready=1: outputs 1, 2, 3, 4 in order, and out_valid=0 after the 4th.
- Steady stream with in_valid=1 and out_ready=1 from count=2:
  - count stays 2 and entries emerge in order.
  - Push 6 entries to exercise pointer wrap.
- Push 3 entries, then assert rst_n=0 for one cycle between clock edges:
  - Immediately: count=0, out_valid=0, in_ready=1, ovf_sticky=0.
  - The next push appears alone at the head.
